// File: rtl/whirlpool_pkg.sv
// Shared types and constants for the Whirlpool round controller.
//   WP_ROUNDS       : rounds per compression (10)
//   WP_RND_W        : width of the round index bus
//   WP_CYC_W        : width of the cycles-per-round counter (CYC_PER_RND 1..4)
//   wp_ctrl_state_t : sequencer state encoding
package whirlpool_pkg;
  localparam int unsigned WP_ROUNDS = 10;
  localparam int unsigned WP_RND_W  = 4;
  localparam int unsigned WP_CYC_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FEED  = 3'd3,
    ST_DOUT  = 3'd4
  } wp_ctrl_state_t;
endpackage

// File: rtl/whirlpool_round_ctrl_if.sv
// Message-block and digest handshakes between the block source and the controller.
//   blk_valid/blk_ready : block offer/accept, qualified by blk_first/blk_last
//   dig_valid/dig_ready : final digest present/consumed
// master = block source / digest sink, slave = round controller.
interface whirlpool_round_ctrl_if;
  logic blk_valid;
  logic blk_ready;
  logic blk_first;
  logic blk_last;
  logic dig_valid;
  logic dig_ready;

  modport master (
    output blk_valid, blk_first, blk_last, dig_ready,
    input  blk_ready, dig_valid
  );

  modport slave (
    input  blk_valid, blk_first, blk_last, dig_ready,
    output blk_ready, dig_valid
  );
endinterface

// File: rtl/whirlpool_rnd_cnt.sv
// Round index / cycle-within-round counter pair.
//   i_clr      : force both counters to 0 (priority)
//   i_load     : start a compression at round 1, cycle 0
//   i_run      : count while rounds are in progress
//   o_rnd      : current round index
//   o_step_c   : last cycle of the current round (round strobe)
//   o_wrap_c   : step of the final round
module whirlpool_rnd_cnt
  import whirlpool_pkg::*;
#(
  parameter int unsigned CYC_PER_RND = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic                i_run,
  output logic [WP_RND_W-1:0] o_rnd,
  output logic                o_step_c,
  output logic                o_wrap_c
);
  logic [WP_RND_W-1:0] r_rnd;
  logic [WP_CYC_W-1:0] r_cyc;

  assign o_rnd    = r_rnd;
  assign o_step_c = i_run & (r_cyc == WP_CYC_W'(CYC_PER_RND - 1));
  assign o_wrap_c = o_step_c & (r_rnd == WP_RND_W'(WP_ROUNDS));

  // Round advances on the last cycle of each group; wrap parks the index at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd <= '0;
      r_cyc <= '0;
    end else if (i_clr) begin
      r_rnd <= '0;
      r_cyc <= '0;
    end else if (i_load) begin
      r_rnd <= WP_RND_W'(1);
      r_cyc <= '0;
    end else if (o_step_c) begin
      r_rnd <= o_wrap_c ? '0 : r_rnd + WP_RND_W'(1);
      r_cyc <= '0;
    end else if (i_run) begin
      r_cyc <= r_cyc + WP_CYC_W'(1);
    end
  end
endmodule

// File: rtl/whirlpool_round_ctrl.sv
// Sequencer for the Whirlpool compression datapath (no 512-bit storage here).
//   clk, rst_n : clock, async active-low reset
//   abort      : synchronous clear back to IDLE, suppresses all strobes
//   blk        : block offer and digest handshakes (slave side)
//   m_ld, h_clr, ld_init, rnd_en, ff_en : datapath strobes
//   round      : round index to the constant generator, 0 outside ROUND
//   busy       : sequencer not idle
//   seq_err    : sticky message-framing error
module whirlpool_round_ctrl
  import whirlpool_pkg::*;
#(
  parameter int unsigned CYC_PER_RND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  whirlpool_round_ctrl_if.slave blk,
  output logic                  m_ld,
  output logic                  h_clr,
  output logic                  ld_init,
  output logic                  rnd_en,
  output logic                  ff_en,
  output logic [WP_RND_W-1:0]   round,
  output logic                  busy,
  output logic                  seq_err
);
  wp_ctrl_state_t      r_state, w_next;
  logic                r_last, w_last;
  logic                r_msg_open, w_msg_open;
  logic                r_seq_err, w_seq_err;
  logic                w_accept;
  logic                w_cnt_load, w_cnt_run;
  logic                w_step, w_wrap;
  logic [WP_RND_W-1:0] w_rnd;

  // Counter controls come straight from the state register to keep the strobe path loop-free.
  assign w_cnt_load = (r_state == ST_INIT)  & ~abort;
  assign w_cnt_run  = (r_state == ST_ROUND) & ~abort;

  whirlpool_rnd_cnt #(.CYC_PER_RND(CYC_PER_RND)) u_rnd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (abort),
    .i_load   (w_cnt_load),
    .i_run    (w_cnt_run),
    .o_rnd    (w_rnd),
    .o_step_c (w_step),
    .o_wrap_c (w_wrap)
  );

  assign blk.blk_ready = (r_state == ST_IDLE) & ~abort;
  assign blk.dig_valid = (r_state == ST_DOUT);
  assign w_accept      = blk.blk_ready & blk.blk_valid;
  assign busy          = (r_state != ST_IDLE);
  assign round         = (r_state == ST_ROUND) ? w_rnd : '0;
  assign seq_err       = r_seq_err;

  // State and message-framing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b0;
      r_msg_open <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_last     <= w_last;
      r_msg_open <= w_msg_open;
      r_seq_err  <= w_seq_err;
    end
  end

  // Next-state and strobe decode; abort overrides everything.
  always_comb begin
    w_next     = r_state;
    w_last     = r_last;
    w_msg_open = r_msg_open;
    w_seq_err  = r_seq_err;
    m_ld       = 1'b0;
    h_clr      = 1'b0;
    ld_init    = 1'b0;
    rnd_en     = 1'b0;
    ff_en      = 1'b0;
    if (abort) begin
      w_next     = ST_IDLE;
      w_msg_open = 1'b0;
      w_seq_err  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            m_ld  = 1'b1;
            // A first block always restarts H; so does any block with no message open.
            h_clr = blk.blk_first | ~r_msg_open;
            // Framing error: first on an open message, or a continuation with none open.
            if (blk.blk_first == r_msg_open) w_seq_err = 1'b1;
            w_last     = blk.blk_last;
            w_msg_open = 1'b1;
            w_next     = ST_INIT;
          end
        end
        ST_INIT: begin
          ld_init = 1'b1;
          w_next  = ST_ROUND;
        end
        ST_ROUND: begin
          rnd_en = w_step;
          if (w_wrap) w_next = ST_FEED;
        end
        ST_FEED: begin
          ff_en  = 1'b1;
          w_next = r_last ? ST_DOUT : ST_IDLE;
        end
        ST_DOUT: begin
          if (blk.dig_ready) begin
            w_msg_open = 1'b0;
            w_next     = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_whirlpool_round_ctrl.sv
// Bench for whirlpool_round_ctrl: two instances (1 and 3 cycles per round) share one
// stimulus stream and are compared every cycle against a timeline model that tracks
// cycles elapsed since each block accept.
module tb_whirlpool_round_ctrl;
  import whirlpool_pkg::*;

  // Bit positions in the 13-bit observation vector.
  localparam int B_BR = 12, B_ML = 11, B_HC = 10, B_LI = 9, B_RE = 8, B_FF = 7;
  localparam int B_DV = 2, B_BZ = 1, B_SE = 0;

  logic clk;
  logic rst_n;
  logic bv, bf, bl, dr, ab;
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  whirlpool_round_ctrl_if if1 ();
  whirlpool_round_ctrl_if if3 ();

  assign if1.blk_valid = bv;
  assign if1.blk_first = bf;
  assign if1.blk_last  = bl;
  assign if1.dig_ready = dr;
  assign if3.blk_valid = bv;
  assign if3.blk_first = bf;
  assign if3.blk_last  = bl;
  assign if3.dig_ready = dr;

  logic       m_ld1, h_clr1, ld_init1, rnd_en1, ff_en1, busy1, seq_err1;
  logic       m_ld3, h_clr3, ld_init3, rnd_en3, ff_en3, busy3, seq_err3;
  logic [3:0] round1, round3;

  whirlpool_round_ctrl #(.CYC_PER_RND(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .abort(ab), .blk(if1),
    .m_ld(m_ld1), .h_clr(h_clr1), .ld_init(ld_init1), .rnd_en(rnd_en1), .ff_en(ff_en1),
    .round(round1), .busy(busy1), .seq_err(seq_err1)
  );

  whirlpool_round_ctrl #(.CYC_PER_RND(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .abort(ab), .blk(if3),
    .m_ld(m_ld3), .h_clr(h_clr3), .ld_init(ld_init3), .rnd_en(rnd_en3), .ff_en(ff_en3),
    .round(round3), .busy(busy3), .seq_err(seq_err3)
  );

  logic [12:0] obs1, obs3;
  assign obs1 = {if1.blk_ready, m_ld1, h_clr1, ld_init1, rnd_en1, ff_en1, round1,
                 if1.dig_valid, busy1, seq_err1};
  assign obs3 = {if3.blk_ready, m_ld3, h_clr3, ld_init3, rnd_en3, ff_en3, round3,
                 if3.dig_valid, busy3, seq_err3};

  // Reference model: t = cycles since accept (-1 idle), plus DOUT wait and message flags.
  int m_t    [2];
  bit m_dout [2];
  bit m_open [2];
  bit m_err  [2];
  bit m_last [2];

  function automatic int cpr(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_t[d] = -1; m_dout[d] = 0; m_open[d] = 0; m_err[d] = 0; m_last[d] = 0;
    end
  endtask

  function automatic logic [12:0] exp_out(input int d);
    int c = cpr(d);
    int t = m_t[d];
    logic br = 0, ml = 0, hc = 0, li = 0, re = 0, fe = 0, dv = 0, bz = 0;
    logic [3:0] rd = 4'd0;
    if (m_dout[d]) begin
      dv = 1; bz = 1;
    end else if (t < 0) begin
      br = !ab;
      ml = br && bv;
      hc = ml && (bf || !m_open[d]);
    end else begin
      bz = 1;
      if (t == 1) li = !ab;
      else if (t <= 1 + 10 * c) begin
        rd = 4'((t - 2) / c + 1);
        re = !ab && ((t - 2) % c == c - 1);
      end else fe = !ab;
    end
    return {br, ml, hc, li, re, fe, rd, dv, bz, m_err[d]};
  endfunction

  task automatic model_adv(input int d);
    int c = cpr(d);
    if (ab) begin
      m_t[d] = -1; m_dout[d] = 0; m_open[d] = 0; m_err[d] = 0;
    end else if (m_dout[d]) begin
      if (dr) begin m_dout[d] = 0; m_open[d] = 0; end
    end else if (m_t[d] < 0) begin
      if (bv) begin
        if (bf && m_open[d])  m_err[d] = 1;
        if (!bf && !m_open[d]) m_err[d] = 1;
        m_last[d] = bl; m_open[d] = 1; m_t[d] = 1;
      end
    end else if (m_t[d] == 2 + 10 * c) begin
      m_t[d] = -1;
      if (m_last[d]) m_dout[d] = 1;
    end else begin
      m_t[d] = m_t[d] + 1;
    end
  endtask

  // One clock: drive inputs after the falling edge, sample 1 ns later, advance the model.
  task automatic step(input logic v, f, l, r, a,
                      output logic [12:0] o1, o3, e1, e3);
    @(negedge clk);
    bv = v; bf = f; bl = l; dr = r; ab = a;
    #1;
    o1 = obs1; o3 = obs3;
    e1 = exp_out(0); e3 = exp_out(1);
    model_adv(0); model_adv(1);
  endtask

  task automatic test_reset();
    logic [12:0] o1, o3, e1, e3;
    bv = 0; bf = 0; bl = 0; dr = 0; ab = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({obs1[11:0], obs3[11:0]} !== 24'h0)
      $display("FAIL reset_hold got %h %h want 000 000", obs1[11:0], obs3[11:0]);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, o1, o3, e1, e3);
    checks++;
    if ({o1, o3} !== {e1, e3})
      $display("FAIL reset_model got %h %h want %h %h", o1, o3, e1, e3);
    else passes++;
    checks++;
    if ({o1, o3} !== {13'h1000, 13'h1000})
      $display("FAIL reset_idle got %h %h want 1000 1000", o1, o3);
    else passes++;
  endtask

  task automatic test_single_block();
    logic [12:0] o1, o3, e1, e3;
    int li1 = -1, ff1 = -1, ff3 = -1, dv1 = -1, ndv1 = 0, nre1 = 0, nre3 = 0;
    for (int k = 0; k < 36; k++) begin
      step(k == 0, 1, 1, 1, 0, o1, o3, e1, e3);
      checks++;
      if ({o1, o3} !== {e1, e3})
        $display("FAIL single k=%0d got %h %h want %h %h", k, o1, o3, e1, e3);
      else passes++;
      if (o1[B_LI] && li1 < 0) li1 = k;
      if (o1[B_FF] && ff1 < 0) ff1 = k;
      if (o3[B_FF] && ff3 < 0) ff3 = k;
      if (o1[B_DV]) begin ndv1++; if (dv1 < 0) dv1 = k; end
      if (o1[B_RE]) nre1++;
      if (o3[B_RE]) nre3++;
    end
    checks++;
    if ({li1, ff1, dv1, ndv1} !== {32'sd1, 32'sd12, 32'sd13, 32'sd1})
      $display("FAIL single_c1_timeline got init=%0d ff=%0d dv=%0d n=%0d want 1 12 13 1",
               li1, ff1, dv1, ndv1);
    else passes++;
    checks++;
    if ({ff3, nre1, nre3} !== {32'sd32, 32'sd10, 32'sd10})
      $display("FAIL single_c3_feed got ff3=%0d re1=%0d re3=%0d want 32 10 10", ff3, nre1, nre3);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [12:0] o1, o3, e1, e3;
    int acc [3] = '{-1, -1, -1};
    int nacc = 0, nhc = 0, dv1 = -1;
    step(0, 0, 0, 1, 1, o1, o3, e1, e3);
    checks++;
    if ({o1, o3} !== {e1, e3})
      $display("FAIL b2b_clear got %h %h want %h %h", o1, o3, e1, e3);
    else passes++;
    for (int k = 0; k < 46; k++) begin
      step(k <= 26, k < 13, k >= 26, 1, 0, o1, o3, e1, e3);
      checks++;
      if ({o1, o3} !== {e1, e3})
        $display("FAIL b2b k=%0d got %h %h want %h %h", k, o1, o3, e1, e3);
      else passes++;
      if (o1[B_ML]) begin
        if (nacc < 3) acc[nacc] = k;
        nacc++;
      end
      if (o1[B_HC]) nhc++;
      if (o1[B_DV] && dv1 < 0) dv1 = k;
    end
    checks++;
    if ({nacc, acc[0], acc[1], acc[2]} !== {32'sd3, 32'sd0, 32'sd13, 32'sd26})
      $display("FAIL b2b_accepts got n=%0d %0d %0d %0d want 3 0 13 26",
               nacc, acc[0], acc[1], acc[2]);
    else passes++;
    checks++;
    if ({nhc, dv1} !== {32'sd1, 32'sd39})
      $display("FAIL b2b_hclr_dig got hclr=%0d dv=%0d want 1 39", nhc, dv1);
    else passes++;
  endtask

  task automatic test_dout_stall();
    logic [12:0] o1, o3, e1, e3;
    int ndv1 = 0, nbr1 = 0, idle19 = -1;
    step(0, 0, 0, 0, 1, o1, o3, e1, e3);
    checks++;
    if ({o1, o3} !== {e1, e3})
      $display("FAIL stall_clear got %h %h want %h %h", o1, o3, e1, e3);
    else passes++;
    for (int k = 0; k < 36; k++) begin
      step(k == 0, 1, 1, k >= 18, 0, o1, o3, e1, e3);
      checks++;
      if ({o1, o3} !== {e1, e3})
        $display("FAIL stall k=%0d got %h %h want %h %h", k, o1, o3, e1, e3);
      else passes++;
      if (o1[B_DV]) ndv1++;
      if (k >= 13 && k <= 18 && o1[B_BR]) nbr1++;
      if (k == 19) idle19 = o1[B_BZ] ? 0 : 1;
    end
    checks++;
    if ({ndv1, nbr1, idle19} !== {32'sd6, 32'sd0, 32'sd1})
      $display("FAIL stall_dout got dv=%0d rdy=%0d idle=%0d want 6 0 1", ndv1, nbr1, idle19);
    else passes++;
  endtask

  task automatic test_abort();
    logic [12:0] o1, o3, e1, e3;
    int nff1 = 0, bz8 = -1, se8 = -1, hc9 = -1, se10 = -1;
    step(0, 0, 0, 1, 1, o1, o3, e1, e3);
    checks++;
    if ({o1, o3} !== {e1, e3})
      $display("FAIL abort_clear got %h %h want %h %h", o1, o3, e1, e3);
    else passes++;
    for (int k = 0; k < 46; k++) begin
      step(k == 0 || k == 9, k == 0, 1, 1, k == 7, o1, o3, e1, e3);
      checks++;
      if ({o1, o3} !== {e1, e3})
        $display("FAIL abort k=%0d got %h %h want %h %h", k, o1, o3, e1, e3);
      else passes++;
      if (k <= 8 && o1[B_FF]) nff1++;
      if (k == 8) begin bz8 = int'(o1[B_BZ]); se8 = int'(o1[B_SE]); end
      if (k == 9) hc9 = int'(o1[B_HC]);
      if (k == 10) se10 = int'(o1[B_SE]);
    end
    checks++;
    if ({nff1, bz8, se8, hc9, se10} !== {32'sd0, 32'sd0, 32'sd0, 32'sd1, 32'sd1})
      $display("FAIL abort_seq got ff=%0d busy=%0d err=%0d hclr=%0d err2=%0d want 0 0 0 1 1",
               nff1, bz8, se8, hc9, se10);
    else passes++;
    step(0, 0, 0, 1, 1, o1, o3, e1, e3);
    step(0, 0, 0, 1, 0, o1, o3, e1, e3);
    checks++;
    if ({o1[B_SE], o3[B_SE]} !== 2'b00)
      $display("FAIL abort_clears_err got %b %b want 0 0", o1[B_SE], o3[B_SE]);
    else passes++;
  endtask

  task automatic test_async_reset();
    logic [12:0] o1, o3, e1, e3;
    step(0, 0, 0, 1, 1, o1, o3, e1, e3);
    for (int k = 0; k < 5; k++) begin
      step(k == 0, 1, 1, 1, 0, o1, o3, e1, e3);
      checks++;
      if ({o1, o3} !== {e1, e3})
        $display("FAIL areset_pre k=%0d got %h %h want %h %h", k, o1, o3, e1, e3);
      else passes++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, round1, rnd_en1, busy3, round3, rnd_en3} !== 12'h000)
      $display("FAIL areset_async got %b %h %b %b %h %b want 0 0 0 0 0 0",
               busy1, round1, rnd_en1, busy3, round3, rnd_en3);
    else passes++;
    model_reset();
    #3 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, o1, o3, e1, e3);
    checks++;
    if ({o1, o3} !== {e1, e3} || !o1[B_BR] || !o3[B_BR])
      $display("FAIL areset_release got %h %h want %h %h", o1, o3, e1, e3);
    else passes++;
  endtask

  task automatic test_random();
    logic [12:0] o1, o3, e1, e3;
    logic v, f, l, r, a;
    for (int k = 0; k < 800; k++) begin
      v = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 9) < 3);
      l = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 9) < 6);
      a = ($urandom_range(0, 49) == 0);
      step(v, f, l, r, a, o1, o3, e1, e3);
      checks++;
      if ({o1, o3} !== {e1, e3})
        $display("FAIL random k=%0d got %h %h want %h %h", k, o1, o3, e1, e3);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_dout_stall();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
